// File: rtl/framebuffer_writer_if.sv
// Pixel-stream and framebuffer write-port bus between the rasteriser, the writer and the BRAM.
interface framebuffer_writer_if #(
  parameter int CORDW  = 16,
  parameter int COLORW = 12,
  parameter int ADDRW  = 17
);
    logic                     pixValid;
    logic signed [CORDW-1:0]  pixX;
    logic signed [CORDW-1:0]  pixY;
    logic        [COLORW-1:0] pixVal;
    logic                     pixReady;
    logic        [ADDRW-1:0]  memAddr;
    logic        [COLORW-1:0] memData;
    logic                     memWe;
    logic                     memReady;

    modport master (
        output pixValid, pixX, pixY, pixVal, memReady,
        input  pixReady, memAddr, memData, memWe
    );

    modport slave (
        input  pixValid, pixX, pixY, pixVal, memReady,
        output pixReady, memAddr, memData, memWe
    );
endinterface

// File: rtl/framebuffer_writer.sv
// Clips rasteriser pixels, converts (x,y) to a linear address, queues writes in a
// first-word-fall-through FIFO and drains them to the framebuffer; also runs full-screen clears.
module framebuffer_writer #(
    parameter int CORDW      = 16,
    parameter int COLORW     = 12,
    parameter int WIDTH      = 320,
    parameter int HEIGHT     = 240,
    parameter int ADDRW      = 17,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    framebuffer_writer_if.slave  bus,
    input  logic                 clearStart_i,
    input  logic [COLORW-1:0]    clearVal_i,
    output logic                 busy_o,
    output logic                 clearDone_o,
    output logic [15:0]          clipCount_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int EW = ADDRW + COLORW;
    localparam int unsigned LAST = WIDTH * HEIGHT - 1;
    localparam logic signed [CORDW-1:0] W_S = CORDW'(WIDTH);
    localparam logic signed [CORDW-1:0] H_S = CORDW'(HEIGHT);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FLUSH = 2'd1;
    localparam logic [1:0] S_CLEAR = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [EW-1:0]     fifo_q [FIFO_DEPTH];
    logic [PW-1:0]     wptr_q, rptr_q;
    logic [PW:0]       count_q;
    logic [ADDRW-1:0]  clrAddr_q, clrAddr_d;
    logic [COLORW-1:0] clrVal_q, clrVal_d;
    logic              clearDone_q, clearDone_d;
    logic [15:0]       clipCount_q, clipCount_d;

    logic              fifoFull, fifoEmpty, clipped, accept, push, pop;
    logic              pixReady, memWe;
    logic [ADDRW-1:0]  pixAddr, memAddr;
    logic [COLORW-1:0] memData;

    assign fifoFull  = (count_q == (PW+1)'(FIFO_DEPTH));
    assign fifoEmpty = (count_q == '0);

    assign clipped = bus.pixX[CORDW-1] || bus.pixY[CORDW-1] ||
                     (bus.pixX >= W_S) || (bus.pixY >= H_S);
    assign pixAddr = ADDRW'(bus.pixY) * ADDRW'(WIDTH) + ADDRW'(bus.pixX);

    // Outputs are forced quiet while reset is asserted, not just after the async clear settles.
    assign pixReady = !rst && (state_q == S_IDLE) && !fifoFull;
    assign accept   = bus.pixValid && pixReady;
    assign push     = accept && !clipped;
    assign pop      = memWe && bus.memReady && (state_q != S_CLEAR);

    always_comb begin
        memWe   = 1'b0;
        memAddr = '0;
        memData = '0;
        if (!rst) begin
            if (state_q == S_CLEAR) begin
                memWe   = 1'b1;
                memAddr = clrAddr_q;
                memData = clrVal_q;
            end else if (!fifoEmpty) begin
                memWe              = 1'b1;
                {memAddr, memData} = fifo_q[rptr_q];
            end
        end
    end

    assign bus.pixReady = pixReady;
    assign bus.memWe    = memWe;
    assign bus.memAddr  = memAddr;
    assign bus.memData  = memData;
    assign busy_o       = !rst && (state_q != S_IDLE);
    assign clearDone_o  = clearDone_q;
    assign clipCount_o  = clipCount_q;

    always_comb begin
        state_d     = state_q;
        clrAddr_d   = clrAddr_q;
        clrVal_d    = clrVal_q;
        clearDone_d = 1'b0;
        clipCount_d = clipCount_q;
        if (accept && clipped && (clipCount_q != '1))
            clipCount_d = clipCount_q + 16'd1;
        case (state_q)
            S_IDLE: begin
                if (clearStart_i) begin
                    state_d   = S_FLUSH;
                    clrVal_d  = clearVal_i;
                    clrAddr_d = '0;
                end
            end
            S_FLUSH: begin
                if (fifoEmpty)
                    state_d = S_CLEAR;
            end
            S_CLEAR: begin
                if (bus.memReady) begin
                    if (clrAddr_q == ADDRW'(LAST)) begin
                        state_d     = S_IDLE;
                        clearDone_d = 1'b1;
                        clrAddr_d   = '0;
                    end else begin
                        clrAddr_d = clrAddr_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            clrAddr_q   <= '0;
            clrVal_q    <= '0;
            clearDone_q <= 1'b0;
            clipCount_q <= '0;
        end else begin
            state_q     <= state_d;
            clrAddr_q   <= clrAddr_d;
            clrVal_q    <= clrVal_d;
            clearDone_q <= clearDone_d;
            clipCount_q <= clipCount_d;
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            count_q <= count_q + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_q[wptr_q] <= {pixAddr, bus.pixVal};
    end
endmodule

// File: tb/tb_framebuffer_writer.sv
// Directed-vector bench for framebuffer_writer at 320x240 with an 8-entry FIFO.
module tb_framebuffer_writer;
    logic        clk = 1'b0;
    logic        rst;
    logic        clearStart;
    logic [11:0] clearVal;
    logic        busy, clearDone;
    logic [15:0] clipCount;
    int          vectors = 0;
    int          miscompares = 0;

    framebuffer_writer_if #(.CORDW(16), .COLORW(12), .ADDRW(17)) bus ();

    framebuffer_writer #(
        .CORDW(16), .COLORW(12), .WIDTH(320), .HEIGHT(240), .ADDRW(17), .FIFO_DEPTH(8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .clearStart_i (clearStart),
        .clearVal_i   (clearVal),
        .busy_o       (busy),
        .clearDone_o  (clearDone),
        .clipCount_o  (clipCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pix(input int x, input int y, input logic [11:0] v);
        bus.pixValid = 1'b1;
        bus.pixX     = 16'(x);
        bus.pixY     = 16'(y);
        bus.pixVal   = v;
    endtask

    // Waits (bounded) for the first write of a clear; a timeout shows up as a failed check.
    task automatic wait_we(input string tag);
        int n = 0;
        while (bus.memWe !== 1'b1 && n < 8) begin
            chk({tag, " busy"}, 32'(busy), 32'd1);
            tick();
            #1;
            n++;
        end
        chk({tag, " memWe"}, 32'(bus.memWe), 32'd1);
    endtask

    initial begin
        int bad;
        int s6x[7] = '{0, 1, 2, 3, 4, 5, 6};
        int s6y[7] = '{1, 2, 3, 4, 4, 5, 4};
        int s6a[7] = '{320, 641, 962, 1283, 1284, 1605, 1286};

        rst = 1'b1;
        clearStart = 1'b0;
        clearVal = '0;
        bus.pixValid = 1'b0;
        bus.pixX = '0;
        bus.pixY = '0;
        bus.pixVal = '0;
        bus.memReady = 1'b0;
        #2;
        chk("rst pixReady", 32'(bus.pixReady), 32'd0);
        chk("rst memWe", 32'(bus.memWe), 32'd0);
        chk("rst memAddr", 32'(bus.memAddr), 32'd0);
        chk("rst memData", 32'(bus.memData), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst clipCount", 32'(clipCount), 32'd0);
        chk("rst clearDone", 32'(clearDone), 32'd0);
        tick();
        tick();
        rst = 1'b0;

        // 1: single pixel
        bus.memReady = 1'b1;
        set_pix(32, 17, 12'hABC);
        #1;
        chk("t1 pixReady", 32'(bus.pixReady), 32'd1);
        chk("t1 idle memWe", 32'(bus.memWe), 32'd0);
        tick();
        bus.pixValid = 1'b0;
        #1;
        chk("t1 write", {bus.memWe, bus.memAddr, bus.memData}, {1'b1, 17'd5472, 12'hABC});
        tick();
        #1;
        chk("t1 one cycle", 32'(bus.memWe), 32'd0);

        // 2: clipping
        set_pix(-1, 0, 12'h001);
        #1;
        chk("t2 p0 ready", 32'(bus.pixReady), 32'd1);
        tick();
        set_pix(320, 5, 12'h002);
        #1;
        chk("t2 p1 ready", 32'(bus.pixReady), 32'd1);
        tick();
        set_pix(0, 240, 12'h003);
        #1;
        chk("t2 p2 ready", 32'(bus.pixReady), 32'd1);
        tick();
        set_pix(319, 239, 12'h004);
        #1;
        chk("t2 p3 ready", 32'(bus.pixReady), 32'd1);
        chk("t2 no clipped write", 32'(bus.memWe), 32'd0);
        tick();
        bus.pixValid = 1'b0;
        #1;
        chk("t2 corner write", {bus.memWe, bus.memAddr, bus.memData}, {1'b1, 17'd76799, 12'h004});
        chk("t2 clipCount", 32'(clipCount), 32'd3);
        tick();
        #1;
        chk("t2 single write", 32'(bus.memWe), 32'd0);

        // 3: backpressure, 9 pixels into an 8-deep FIFO
        bus.memReady = 1'b0;
        for (int i = 0; i < 9; i++) begin
            set_pix(i, 0, 12'(12'h100 + i));
            #1;
            chk($sformatf("t3 ready %0d", i), 32'(bus.pixReady), (i < 8) ? 32'd1 : 32'd0);
            tick();
        end
        chk("t3 stalled head", {bus.memWe, bus.memAddr, bus.memData}, {1'b1, 17'd0, 12'h100});
        bus.pixValid = 1'b0;
        bus.memReady = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk($sformatf("t3 drain %0d", k), {bus.memWe, bus.memAddr, bus.memData},
                {1'b1, 17'(k), 12'(12'h100 + k)});
            tick();
        end
        #1;
        chk("t3 drained memWe", 32'(bus.memWe), 32'd0);
        chk("t3 ready again", 32'(bus.pixReady), 32'd1);

        // 4: clear after two queued pixels; a clearStart mid-clear is ignored
        set_pix(10, 0, 12'h111);
        #1;
        tick();
        set_pix(11, 0, 12'h222);
        clearStart = 1'b1;
        clearVal = 12'h000;
        #1;
        chk("t4 first pixel", {bus.memWe, bus.memAddr, bus.memData}, {1'b1, 17'd10, 12'h111});
        tick();
        bus.pixValid = 1'b0;
        clearStart = 1'b0;
        #1;
        chk("t4 second pixel", {bus.memWe, bus.memAddr, bus.memData}, {1'b1, 17'd11, 12'h222});
        chk("t4 busy", 32'(busy), 32'd1);
        chk("t4 not ready", 32'(bus.pixReady), 32'd0);
        tick();
        #1;
        wait_we("t4 start");
        bad = 0;
        for (int a = 0; a < 76800; a++) begin
            if (bus.memWe !== 1'b1 || bus.memAddr !== 17'(a) || bus.memData !== 12'h000 ||
                busy !== 1'b1 || bus.pixReady !== 1'b0 || clearDone !== 1'b0)
                bad++;
            clearStart = (a == 500);
            clearVal = (a == 500) ? 12'hFFF : 12'h000;
            tick();
            #1;
        end
        clearStart = 1'b0;
        chk("t4 clear bad cycles", 32'(bad), 32'd0);
        chk("t4 clearDone", 32'(clearDone), 32'd1);
        chk("t4 idle busy", 32'(busy), 32'd0);
        chk("t4 idle memWe", 32'(bus.memWe), 32'd0);
        chk("t4 idle ready", 32'(bus.pixReady), 32'd1);
        tick();
        #1;
        chk("t4 clearDone pulse", 32'(clearDone), 32'd0);

        // 5: reset in the middle of a clear
        clearStart = 1'b1;
        clearVal = 12'h5A5;
        tick();
        clearStart = 1'b0;
        #1;
        wait_we("t5 start");
        chk("t5 first addr", 32'(bus.memAddr), 32'd0);
        for (int a = 0; a < 1000; a++) tick();
        #1;
        chk("t5 at 1000", {bus.memAddr, bus.memData}, {17'd1000, 12'h5A5});
        rst = 1'b1;
        #1;
        chk("t5 rst memWe", 32'(bus.memWe), 32'd0);
        chk("t5 rst ready", 32'(bus.pixReady), 32'd0);
        chk("t5 rst clipCount", 32'(clipCount), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("t5 busy after", 32'(busy), 32'd0);
        chk("t5 ready after", 32'(bus.pixReady), 32'd1);
        chk("t5 memWe after", 32'(bus.memWe), 32'd0);
        clearStart = 1'b1;
        clearVal = 12'h123;
        tick();
        clearStart = 1'b0;
        #1;
        wait_we("t5 restart");
        chk("t5 restart addr", {bus.memAddr, bus.memData}, {17'd0, 12'h123});
        tick();
        #1;
        chk("t5 restart next", 32'(bus.memAddr), 32'd1);
        rst = 1'b1;
        #1;
        tick();
        rst = 1'b0;
        #1;

        // 6: rasterised line streamed at one pixel per cycle
        for (int i = 0; i < 8; i++) begin
            if (i < 7) set_pix(s6x[i], s6y[i], 12'(i + 1));
            else       bus.pixValid = 1'b0;
            #1;
            if (i < 7) chk($sformatf("t6 ready %0d", i), 32'(bus.pixReady), 32'd1);
            if (i == 0) chk("t6 no write yet", 32'(bus.memWe), 32'd0);
            else chk($sformatf("t6 write %0d", i - 1), {bus.memWe, bus.memAddr, bus.memData},
                     {1'b1, 17'(s6a[i-1]), 12'(i)});
            tick();
        end
        #1;
        chk("t6 done", 32'(bus.memWe), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end
endmodule
